// File: rtl/logical_shift.sv
// logical_shift: registered 8-bit logical shifter (ALU shift unit), zero fill both directions
// Ports:
//   RESULT      out 8  registered shift result
//   DATA        in  8  operand
//   SHIFT       in  8  unsigned shift amount; 8 and above yields zero
//   SHIFTsignal in  1  0 = left, 1 = right
//   CLK         in  1  rising-edge clock
//   RESET       in  1  asynchronous active-low reset
module logical_shift (
  output logic [7:0] RESULT,
  input  logic [7:0] DATA,
  input  logic [7:0] SHIFT,
  input  logic       SHIFTsignal,
  input  logic       CLK,
  input  logic       RESET
);
  logic [7:0] din, s1, s2, s4, dout, nxt;
  // Right shifts reuse the left-shift barrel by bit-reversing operand and result
  for (genvar i = 0; i < 8; i++) begin : g_rev
    assign din[i]  = SHIFTsignal ? DATA[7-i] : DATA[i];
    assign dout[i] = SHIFTsignal ? s4[7-i] : s4[i];
  end
  always_comb begin
    s1  = SHIFT[0] ? {din[6:0], 1'b0} : din;
    s2  = SHIFT[1] ? {s1[5:0], 2'b0} : s1;
    s4  = SHIFT[2] ? {s2[3:0], 4'b0} : s2;
    // Amounts of 8 or more must clear the result, not wrap modulo 8
    nxt = |SHIFT[7:3] ? 8'h00 : dout;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) RESULT <= 8'h00;
    else RESULT <= nxt;
endmodule

// File: tb/tb_logical_shift.sv
// tb_logical_shift: self-checking bench for logical_shift
module tb_logical_shift;
  logic [7:0] RESULT, DATA, SHIFT;
  logic       SHIFTsignal, CLK, RESET;
  int passed = 0;
  int total = 0;

  logical_shift dut (
    .RESULT(RESULT), .DATA(DATA), .SHIFT(SHIFT),
    .SHIFTsignal(SHIFTsignal), .CLK(CLK), .RESET(RESET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic [7:0] shift;
    logic       dir;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] model(input logic [7:0] d, input logic [7:0] s, input logic dir);
    int p;
    if (s >= 8) return 8'h00;
    p = 1 << s;
    return dir ? 8'(int'(d) / p) : 8'((int'(d) * p) % 256);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [7:0] d, input logic [7:0] s, input logic dir);
    DATA = d;
    SHIFT = s;
    SHIFTsignal = dir;
  endtask

  task automatic step(input string name, input logic [7:0] exp);
    @(posedge CLK);
    #1 check(name, RESULT, exp);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{8'hB3, 8'd0, 1'b0, 8'hB3});
    vecs.push_back('{8'hB3, 8'd1, 1'b0, 8'h66});
    vecs.push_back('{8'hB3, 8'd3, 1'b0, 8'h98});
    vecs.push_back('{8'hB3, 8'd7, 1'b0, 8'h80});
    vecs.push_back('{8'hB3, 8'd0, 1'b1, 8'hB3});
    vecs.push_back('{8'hB3, 8'd1, 1'b1, 8'h59});
    vecs.push_back('{8'hB3, 8'd3, 1'b1, 8'h16});
    vecs.push_back('{8'hB3, 8'd7, 1'b1, 8'h01});
    foreach (vecs[k]) ;
    for (int d = 0; d < 2; d++) begin
      vecs.push_back('{8'hFF, 8'd8, d[0], 8'h00});
      vecs.push_back('{8'hFF, 8'd9, d[0], 8'h00});
      vecs.push_back('{8'hFF, 8'd16, d[0], 8'h00});
      vecs.push_back('{8'hFF, 8'd255, d[0], 8'h00});
    end

    RESET = 1'b1;
    drive(8'hFF, 8'd1, 1'b0);
    #1 RESET = 1'b0;
    #1 check("reset_async", RESULT, 8'h00);
    for (int i = 0; i < 3; i++) step("reset_hold", 8'h00);
    @(negedge CLK) RESET = 1'b1;
    step("reset_release", 8'hFE);

    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].shift, vecs[i].dir);
      step($sformatf("vec%0d", i), vecs[i].exp);
      check($sformatf("vec%0d_model", i), RESULT, model(vecs[i].data, vecs[i].shift, vecs[i].dir));
    end

    drive(8'h3C, 8'd2, 1'b1);
    step("hold_a", 8'h0F);
    drive(8'hFF, 8'd0, 1'b0);
    #3 check("hold_between_edges", RESULT, 8'h0F);

    for (int i = 0; i < 20; i++) begin
      logic [7:0] d, s;
      logic dir;
      d = 8'($urandom);
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      dir = 1'($urandom);
      drive(d, s, dir);
      step($sformatf("rand%0d", i), model(d, s, dir));
    end

    drive(8'hA5, 8'd0, 1'b1);
    step("pre_async", 8'hA5);
    drive(8'h81, 8'd1, 1'b0);
    #1 RESET = 1'b0;
    #1 check("async_mid", RESULT, 8'h00);
    #1 RESET = 1'b1;
    #1 check("async_hold", RESULT, 8'h00);
    step("after_async", 8'h02);
    drive(8'h81, 8'd1, 1'b1);
    step("after_async2", 8'h40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
